// File: rtl/orange_centroid_tracker.sv
// rtl/orange_centroid_tracker.sv - per-frame orange pixel centroid with left/centre/right steering
module orange_centroid_tracker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 64,
  parameter int DEADBAND   = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic        vsync,
  input  logic        is_orange,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic [18:0] pixel_count,
  output logic        detected,
  output logic [1:0]  direction,
  output logic        result_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_END     = 10'(V_ACTIVE);
  localparam logic [9:0]  LEFT_LIM  = 10'(H_ACTIVE / 2 - DEADBAND);
  localparam logic [9:0]  RIGHT_LIM = 10'(H_ACTIVE / 2 + DEADBAND);
  localparam logic [18:0] MIN_CNT   = 19'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y} state_t;
  state_t state, state_next;

  logic        vsync_q;
  logic [9:0]  x, y;
  logic [18:0] acc_count;
  logic [28:0] acc_sx, acc_sy;
  logic [18:0] snap_count;
  logic [28:0] snap_sy;
  logic [28:0] rem;
  logic [9:0]  quo, quo_x;
  logic [3:0]  div_i;

  logic        fe, hit, take_snap, start_div, skip, q_bit;
  logic [18:0] count_in;
  logic [28:0] sx_in, sy_in, divisor, diff;
  logic [9:0]  quo_next;

  function automatic logic [1:0] steer(input logic [9:0] cx);
    if (cx < LEFT_LIM)       return 2'b01;
    else if (cx > RIGHT_LIM) return 2'b10;
    else                     return 2'b11;
  endfunction

  // Accumulator values including the current pixel; these feed both the
  // running sums and the frame-end snapshot.
  always_comb begin
    fe        = vsync_q && !vsync;
    hit       = pix_valid && is_orange && (y < Y_END);
    count_in  = acc_count + 19'(hit);
    sx_in     = acc_sx + (hit ? 29'(x) : 29'd0);
    sy_in     = acc_sy + (hit ? 29'(y) : 29'd0);
    take_snap = fe && (state == IDLE);
    start_div = take_snap && (count_in >= MIN_CNT) && (count_in != '0);
    skip      = take_snap && !start_div;
    divisor   = 29'(snap_count) << div_i;
    diff      = rem - divisor;
    q_bit     = (rem >= divisor);
    quo_next  = {quo[8:0], q_bit};
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:    if (start_div) state_next = DIV_X;
      DIV_X:   if (div_i == 4'd0) state_next = DIV_Y;
      DIV_Y:   if (div_i == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q   <= 1'b1;
      x         <= '0;
      y         <= '0;
      acc_count <= '0;
      acc_sx    <= '0;
      acc_sy    <= '0;
    end else begin
      vsync_q <= vsync;
      if (fe) begin
        x         <= '0;
        y         <= '0;
        acc_count <= '0;
        acc_sx    <= '0;
        acc_sy    <= '0;
      end else begin
        if (pix_valid) begin
          if (x == X_LAST) begin
            x <= '0;
            if (y < Y_END) y <= y + 10'd1;
          end else begin
            x <= x + 10'd1;
          end
        end
        acc_count <= count_in;
        acc_sx    <= sx_in;
        acc_sy    <= sy_in;
      end
    end
  end

  // Snapshot and divider; rem holds the x sum first, then the y sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      snap_count   <= '0;
      snap_sy      <= '0;
      rem          <= '0;
      quo          <= '0;
      quo_x        <= '0;
      div_i        <= '0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      pixel_count  <= '0;
      detected     <= 1'b0;
      direction    <= 2'b00;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      result_valid <= 1'b0;
      overrun      <= fe && (state != IDLE);
      case (state)
        IDLE: begin
          if (take_snap) begin
            snap_count <= count_in;
            snap_sy    <= sy_in;
            rem        <= sx_in;
            div_i      <= 4'd9;
          end
          if (skip) begin
            result_valid <= 1'b1;
            detected     <= 1'b0;
            direction    <= 2'b00;
            pixel_count  <= count_in;
          end
        end
        DIV_X: begin
          quo <= quo_next;
          if (div_i == 4'd0) begin
            quo_x <= quo_next;
            rem   <= snap_sy;
            div_i <= 4'd9;
          end else begin
            rem   <= q_bit ? diff : rem;
            div_i <= div_i - 4'd1;
          end
        end
        DIV_Y: begin
          quo <= quo_next;
          if (div_i == 4'd0) begin
            centroid_x   <= quo_x;
            centroid_y   <= quo_next;
            pixel_count  <= snap_count;
            detected     <= 1'b1;
            direction    <= steer(quo_x);
            result_valid <= 1'b1;
          end else begin
            rem   <= q_bit ? diff : rem;
            div_i <= div_i - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/orange_centroid_tracker.md
Name: orange_centroid_tracker

Overview:
- Downstream consumer of the per-pixel orange flag produced by target_finder, running in the 25 MHz VGA pixel domain.
- Tracks raster position from the VGA active-area strobe and vsync.
- Accumulates the count and the coordinate sums of orange pixels over each frame.
- At frame end, runs a sequential shift-subtract divider to produce a registered centroid, a detected flag and a left/centre/right steering decision for the classification/LED logic.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- MIN_PIXELS, 64: minimum orange pixel count per frame to declare detection.
- DEADBAND, 40: half-width of the centre zone around H_ACTIVE/2, in pixels.

Ports:
- clk  in  1  25 MHz pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- pix_valid  in  1  high for each active-area pixel (activeArea).
- vsync  in  1  VGA vsync, active low.
- is_orange  in  1  orange flag for the current pixel; qualified by pix_valid.
- centroid_x  out  10  frame centroid column.
- centroid_y  out  10  frame centroid row.
- pixel_count  out  19  orange pixels counted in the last completed frame.
- detected  out  1  last frame had pixel_count >= MIN_PIXELS.
- direction  out  2  00 none, 01 left, 10 right, 11 centre.
- result_valid  out  1  one-cycle pulse when all outputs above update.
- busy  out  1  divider running.
- overrun  out  1  one-cycle pulse when a frame end is dropped.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). All state is sampled on rising clk.
- Reset values: all outputs 0; x, y and accumulators 0; state IDLE; vsync_q = 1.
- Frame-end event (FE): vsync_q==1 && vsync==0. In the same edge:
  - x and y are cleared.
  - acc_count, acc_sx and acc_sy are cleared.
  - Snapshot registers load acc values, including the current pixel if it is valid and orange.
- Raster tracking:
  - On pix_valid, x increments.
  - When x==H_ACTIVE-1, x wraps to 0 and y increments.
  - y saturates at V_ACTIVE; pixels with y==V_ACTIVE are ignored. This guarantees no accumulator overflow without vsync.
- Accumulation: on pix_valid && is_orange && y<V_ACTIVE:
  - acc_count += 1 (19 bits).
  - acc_sx += x and acc_sy += y (29 bits each; no overflow possible).
- State machine (IDLE, DIV_X, DIV_Y):
  - IDLE + FE with snap_count >= MIN_PIXELS (and snap_count != 0) → DIV_X; busy=1.
  - IDLE + FE with snap_count < MIN_PIXELS → stay IDLE. Next cycle: result_valid=1, detected=0, direction=00, pixel_count=snap_count; centroid outputs hold their previous values.
  - DIV_X: 10 cycles, restoring divide for i=9..0: if rem >= (count<<i), then rem -= count<<i and q[i]=1. Then → DIV_Y.
  - DIV_Y: same 10 cycles on snap_sy. On the last cycle the outputs are registered, result_valid=1 for one cycle, busy=0, → IDLE.
  - Quotient is the floor of the mean; the remainder is discarded.
- Latency: with FE at edge E, result_valid is high in cycle E+21 on the divide path, and in cycle E+1 on the skip path.
- Direction, evaluated on the new centroid_x:
  - < H_ACTIVE/2-DEADBAND → 01.
  - > H_ACTIVE/2+DEADBAND → 10.
  - Otherwise → 11.
  - Boundaries are inclusive to centre.
- FE while busy: the snapshot is not taken and the divide continues undisturbed. The accumulators are still cleared, the frame is dropped, and overrun pulses for 1 cycle.
- Reset mid-divide: rst_n low for one edge aborts the divide. The state machine returns to IDLE and all outputs return to their reset values, with no result_valid pulse.
- Accumulation runs concurrently with the divider; snapshot registers are isolated from the accumulators.

Test Plan:
- MIN_PIXELS=1; a single orange pixel at (100,50), then FE → 21 cycles later result_valid=1, centroid (100,50), pixel_count=1, detected=1, direction=01.
- 20x20 orange block at x 400..419, y 200..219 → pixel_count=400, centroid (409,209), direction=10, result_valid exactly 21 cycles after FE.
- 10 orange pixels with MIN_PIXELS=64 → result_valid at E+1, detected=0, direction=00, pixel_count=10, centroid unchanged from the prior frame.
- Block centred at x=300 and at x=280 (boundary) → direction=11 in both cases; block at x=279 → direction=01.
- Second vsync falling edge 5 cycles after FE → overrun pulses once; the first frame's result is still delivered at E+21 and is correct; the second frame produces no result.
- Assert rst_n=0 during DIV_Y → next cycle all outputs 0, busy=0; the following full frame produces a correct result.
